// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction cache and decode.
// The master side is the fetch unit; the slave side is its environment
// (cache, decode and the redirect source).
interface instruction_fetch_unit_if #(
    parameter int addr_width = 64,
    parameter int data_width = 32
);
    logic                  redirect_valid;
    logic [addr_width-1:0] redirect_pc;
    logic [addr_width-1:0] cache_address;
    logic                  cache_read_enable;
    logic [data_width-1:0] cache_read_data;
    logic                  cache_data_valid;
    logic                  fetch_valid;
    logic                  fetch_ready;
    logic [data_width-1:0] fetch_instruction;
    logic [addr_width-1:0] fetch_pc;

    modport master (
        input  redirect_valid, redirect_pc, cache_read_data, cache_data_valid, fetch_ready,
        output cache_address, cache_read_enable, fetch_valid, fetch_instruction, fetch_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, cache_read_data, cache_data_valid, fetch_ready,
        input  cache_address, cache_read_enable, fetch_valid, fetch_instruction, fetch_pc
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one level-held read per
// instruction to the cache, and hands each instruction to decode through
// a single-entry valid/ready buffer. Redirects that arrive while a cache
// read is outstanding are parked until the cache answers, since the cache
// cannot abort a request.
module instruction_fetch_unit #(
    parameter int                   addr_width = 64,
    parameter int                   data_width = 32,
    parameter logic [addr_width-1:0] reset_pc  = '0,
    parameter int unsigned          pc_step    = 4
) (
    input logic                      clock,
    input logic                      reset,
    instruction_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [addr_width-1:0] pc_q, pc_d;
    logic [addr_width-1:0] pending_pc_q, pending_pc_d;
    logic [data_width-1:0] instr_q, instr_d;
    logic [addr_width-1:0] fetch_pc_q, fetch_pc_d;
    logic [addr_width-1:0] redirect_target;

    // Instructions are word aligned, so the low two target bits are forced to 0.
    assign redirect_target = bus.redirect_pc & ~{{(addr_width-2){1'b0}}, 2'b11};

    // State, PC and output buffer registers; reset clears them asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= reset_pc;
            pending_pc_q <= '0;
            instr_q      <= '0;
            fetch_pc_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
            instr_q      <= instr_d;
            fetch_pc_q   <= fetch_pc_d;
        end
    end

    // Next-state logic: request sequencing, redirect handling and PC advance.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        instr_d      = instr_q;
        fetch_pc_d   = fetch_pc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.redirect_valid) pc_d = redirect_target;
                state_d = FETCH;
            end
            FETCH: begin
                if (bus.redirect_valid && bus.cache_data_valid) begin
                    // Response belongs to the old path; re-issue at the target.
                    pc_d = redirect_target;
                end else if (bus.redirect_valid) begin
                    // Read still in flight: park the target until it returns.
                    pending_pc_d = redirect_target;
                    state_d      = DRAIN;
                end else if (bus.cache_data_valid) begin
                    instr_d    = bus.cache_read_data;
                    fetch_pc_d = pc_q;
                    state_d    = HOLD;
                end
            end
            DRAIN: begin
                if (bus.cache_data_valid) begin
                    pc_d    = bus.redirect_valid ? redirect_target : pending_pc_q;
                    state_d = FETCH;
                end else if (bus.redirect_valid) begin
                    pending_pc_d = redirect_target;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    // Held instruction is either consumed this cycle or dropped.
                    pc_d    = redirect_target;
                    state_d = FETCH;
                end else if (bus.fetch_ready) begin
                    pc_d    = pc_q + addr_width'(pc_step);
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cache_read_enable = (state_q == FETCH) || (state_q == DRAIN);
    assign bus.cache_address     = pc_q;
    assign bus.fetch_valid       = (state_q == HOLD);
    assign bus.fetch_instruction = instr_q;
    assign bus.fetch_pc          = fetch_pc_q;

endmodule
